rca_share_arbiter: RTL

//  Shares one pipelined ripple-carry adder (fixed latency, no stall) among NREQ requesters.
//  - Round-robin arbitration selects one requester per cycle and issues its operands to the adder.
//  - A tag pipeline tracks which requester owns each in-flight operation.
//  - Results are buffered in an in-order response FIFO with valid/ready backpressure.
//  - Credit control ensures an adder result is never dropped.

---
 rtl/rca_share_arbiter_if.sv | 30 +++
 rtl/rca_share_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rca_share_arbiter_if.sv
// rtl/rca_share_arbiter_if.sv - request, shared-adder and response signal bundle for rca_share_arbiter
interface rca_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      add_x;
  logic [WIDTH-1:0]      add_y;
  logic [WIDTH-1:0]      add_s;
  logic                  add_co;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH:0]        rsp_sum;

  modport master (
    input  req_valid, req_a, req_b, add_s, add_co, rsp_ready,
    output req_ready, add_x, add_y, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    output req_valid, req_a, req_b, add_s, add_co, rsp_ready,
    input  req_ready, add_x, add_y, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/rca_share_arbiter.sv
// rtl/rca_share_arbiter.sv - round-robin sharing of one pipelined adder with tagged, credited in-order responses
// Optional: define RCA_ARB_PRIO_EN to give requester 0 fixed top priority.
module rca_share_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 4,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  rca_share_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int ENT_W = ID_W + WIDTH + 1;

`ifdef RCA_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif
  localparam int FIRST_RR = PRIO_EN ? 1 : 0;

  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           grant_id;
  logic                      any_req;
  logic                      credit;
  logic                      issue;
  logic [WIDTH-1:0]          sel_a;
  logic [WIDTH-1:0]          sel_b;
  int                        best_rank;
  int                        rank_i;
  logic [LAT:0]              tag_v;
  logic [LAT:0][ID_W-1:0]    tag_id;
  logic [CNT_W-1:0]          inflight;
  logic [CNT_W-1:0]          count;
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW-1:0]             head_idx;
  logic [ENT_W-1:0]          mem [FIFO_DEPTH];
  logic                      push;
  logic                      pop;

  // Rank 0 is the requester just after ptr; the lowest-ranked valid requester wins.
  always_comb begin
    any_req   = 1'b0;
    grant_id  = '0;
    sel_a     = '0;
    sel_b     = '0;
    best_rank = NREQ;
    rank_i    = 0;
    for (int i = FIRST_RR; i < NREQ; i++) begin
      rank_i = (i > int'(ptr)) ? (i - int'(ptr) - 1) : (i + NREQ - int'(ptr) - 1);
      if (bus.req_valid[i] && (rank_i < best_rank)) begin
        best_rank = rank_i;
        any_req   = 1'b1;
        grant_id  = ID_W'(i);
        sel_a     = bus.req_a[i*WIDTH +: WIDTH];
        sel_b     = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
    if (PRIO_EN && bus.req_valid[0]) begin
      any_req  = 1'b1;
      grant_id = '0;
      sel_a    = bus.req_a[WIDTH-1:0];
      sel_b    = bus.req_b[WIDTH-1:0];
    end
  end

  // Every in-flight op owns a FIFO slot, so a captured result always has room.
  assign credit        = ({1'b0, inflight} + {1'b0, count}) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue         = credit && any_req;
  assign bus.req_ready = issue ? (NREQ'(1) << grant_id) : '0;

  assign push          = tag_v[LAT];
  assign bus.rsp_valid = (count != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign head_idx      = (count == '0) ? (rd_ptr - AW'(1)) : rd_ptr;
  assign {bus.rsp_id, bus.rsp_sum} = mem[head_idx];

  // tag stage 0 runs alongside add_x/add_y, stage LAT alongside add_s/add_co.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= ID_W'(NREQ - 1);
      bus.add_x <= '0;
      bus.add_y <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
      inflight  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (issue && !(PRIO_EN && (grant_id == '0))) begin
        ptr <= grant_id;
      end
      bus.add_x <= issue ? sel_a : '0;
      bus.add_y <= issue ? sel_b : '0;
      tag_v     <= {tag_v[LAT-1:0], issue};
      tag_id    <= {tag_id[LAT-1:0], grant_id};

      if (issue && !push) begin
        inflight <= inflight + CNT_W'(1);
      end else if (!issue && push) begin
        inflight <= inflight - CNT_W'(1);
      end

      if (push) begin
        mem[wr_ptr] <= {tag_id[LAT], bus.add_co, bus.add_s};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(FIFO_DEPTH))));
endmodule
